// File: rtl/inst_pair_buffer.sv
// rtl/inst_pair_buffer.sv - circular buffer accepting instruction pairs and presenting the two oldest to decode
module inst_pair_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_valid,
    input  logic [31:0]              fetch_inst1,
    input  logic [31:0]              fetch_inst2,
    input  logic [31:0]              fetch_pc,
    output logic                     fetch_ready,
    input  logic                     flush,
    input  logic                     stall,
    input  logic                     hazard_control,
    output logic [31:0]              inst1,
    output logic [31:0]              inst2,
    output logic [31:0]              pc1,
    output logic [31:0]              pc2,
    output logic                     inst1_valid,
    output logic                     inst2_valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_plus1;
    logic [AW-1:0] wr_ptr_plus1;
    logic          push;
    logic [1:0]    pop;
    logic [CW-1:0] count_next;

    // Ready ignores any same-cycle pop so it never depends on decode-side inputs.
    assign fetch_ready  = (count <= CW'(DEPTH - 2));
    assign push         = fetch_valid && fetch_ready && !flush;
    assign inst1_valid  = (count >= CW'(1));
    assign inst2_valid  = (count >= CW'(2));
    assign rd_ptr_plus1 = rd_ptr + AW'(1);
    assign wr_ptr_plus1 = wr_ptr + AW'(1);

    always_comb begin
        pop = 2'd0;
        if (!stall && !flush) begin
            if (inst2_valid && !hazard_control) begin
                pop = 2'd2;
            end else if (inst1_valid) begin
                pop = 2'd1;
            end
        end
    end

    assign count_next = count + (push ? CW'(2) : CW'(0)) - CW'(pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count_next;
            rd_ptr <= rd_ptr + AW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(2);
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr]       <= fetch_inst1;
            pc_mem[wr_ptr]         <= fetch_pc;
            inst_mem[wr_ptr_plus1] <= fetch_inst2;
            pc_mem[wr_ptr_plus1]   <= fetch_pc + 32'd4;
        end
    end

    assign inst1 = inst1_valid ? inst_mem[rd_ptr]       : NOP;
    assign pc1   = inst1_valid ? pc_mem[rd_ptr]         : 32'h0;
    assign inst2 = inst2_valid ? inst_mem[rd_ptr_plus1] : NOP;
    assign pc2   = inst2_valid ? pc_mem[rd_ptr_plus1]   : 32'h0;
endmodule

// File: tb/tb_inst_pair_buffer.sv
// tb/tb_inst_pair_buffer.sv - randomized bench for inst_pair_buffer against a queue model
module tb_inst_pair_buffer;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = 2 + 128 + CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_valid;
    logic [31:0]   fetch_inst1;
    logic [31:0]   fetch_inst2;
    logic [31:0]   fetch_pc;
    logic          fetch_ready;
    logic          flush;
    logic          stall;
    logic          hazard_control;
    logic [31:0]   inst1;
    logic [31:0]   inst2;
    logic [31:0]   pc1;
    logic [31:0]   pc2;
    logic          inst1_valid;
    logic          inst2_valid;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;
    logic [63:0] q[$];

    inst_pair_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid),
        .fetch_inst1(fetch_inst1), .fetch_inst2(fetch_inst2), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .flush(flush), .stall(stall),
        .hazard_control(hazard_control), .inst1(inst1), .inst2(inst2),
        .pc1(pc1), .pc2(pc2), .inst1_valid(inst1_valid), .inst2_valid(inst2_valid),
        .count(count)
    );

    always #5 clk = ~clk;

    wire [OW-1:0] obs = {inst1_valid, inst2_valid, inst1, pc1, inst2, pc2, count, fetch_ready};

    // Expected visible state derived from the in-order queue of buffered entries.
    function automatic logic [OW-1:0] m_outs();
        logic [31:0] i1 = NOP, p1 = 32'h0, i2 = NOP, p2 = 32'h0;
        if (q.size() >= 1) {i1, p1} = q[0];
        if (q.size() >= 2) {i2, p2} = q[1];
        return {q.size() >= 1, q.size() >= 2, i1, p1, i2, p2, CW'(q.size()), q.size() <= DEPTH - 2};
    endfunction

    task automatic cycle(input logic fv, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic fl, input logic st, input logic hz);
        int n;
        int pp;
        @(negedge clk);
        rst_n = 1'b1; fetch_valid = fv; fetch_inst1 = a; fetch_inst2 = b; fetch_pc = p;
        flush = fl; stall = st; hazard_control = hz;
        n  = q.size();
        pp = (fl || st) ? 0 : (n >= 2 && !hz) ? 2 : (n >= 1) ? 1 : 0;
        if (fl) begin
            q.delete();
        end else begin
            repeat (pp) void'(q.pop_front());
            if (fv && n <= DEPTH - 2) begin
                q.push_back({a, p});
                q.push_back({b, p + 32'd4});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_push(input logic st, input logic hz);
        cycle(1'b1, $urandom, $urandom, $urandom & 32'hffff_fff8, 1'b0, st, hz);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_valid = 1'b0; fetch_inst1 = '0; fetch_inst2 = '0; fetch_pc = '0;
        flush = 1'b0; stall = 1'b0; hazard_control = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        checks++;
        if (obs !== {1'b0, 1'b0, NOP, 32'h0, NOP, 32'h0, CW'(0), 1'b1}) begin
            errors++; $display("FAIL reset obs=%h exp=%h", obs, {1'b0, 1'b0, NOP, 32'h0, NOP, 32'h0, CW'(0), 1'b1});
        end
    endtask

    task automatic test_basic_pair();
        cycle(1'b1, 32'h0050_0093, 32'h00A0_0113, 32'h100, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== {1'b1, 1'b1, 32'h0050_0093, 32'h100, 32'h00A0_0113, 32'h104, CW'(2), 1'b1}) begin
            errors++; $display("FAIL basic_pair obs=%h exp=%h", obs, {1'b1, 1'b1, 32'h0050_0093, 32'h100, 32'h00A0_0113, 32'h104, CW'(2), 1'b1});
        end
    endtask

    task automatic test_hazard();
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== {1'b1, 1'b0, 32'h00A0_0113, 32'h104, NOP, 32'h0, CW'(1), 1'b1}) begin
            errors++; $display("FAIL hazard_pop1 obs=%h exp=%h", obs, {1'b1, 1'b0, 32'h00A0_0113, 32'h104, NOP, 32'h0, CW'(1), 1'b1});
        end
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== m_outs() || count !== CW'(0)) begin
            errors++; $display("FAIL hazard_drain obs=%h exp=%h", obs, m_outs());
        end
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL hazard_empty obs=%h exp=%h", obs, m_outs());
        end
        repeat (2) rnd_push(1'b1, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL hazard_shift obs=%h exp=%h", obs, m_outs());
        end
    endtask

    task automatic test_full();
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        repeat (3) rnd_push(1'b1, 1'b0);
        checks++;
        if (count !== CW'(6) || fetch_ready !== 1'b1) begin
            errors++; $display("FAIL full_at6 count=%0d ready=%b exp 6/1", count, fetch_ready);
        end
        rnd_push(1'b1, 1'b0);
        checks++;
        if (obs !== m_outs() || count !== CW'(8) || fetch_ready !== 1'b0) begin
            errors++; $display("FAIL full_at8 obs=%h exp=%h", obs, m_outs());
        end
        repeat (3) begin
            rnd_push(1'b1, 1'b0);
            checks++;
            if (obs !== m_outs() || count !== CW'(8)) begin
                errors++; $display("FAIL full_hold obs=%h exp=%h", obs, m_outs());
            end
        end
        // Drain everything in order to confirm nothing was overwritten while full.
        repeat (4) begin
            cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== m_outs()) begin
                errors++; $display("FAIL full_drain obs=%h exp=%h", obs, m_outs());
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] p = 32'h2000;
        repeat (3) rnd_push(1'b1, 1'b0);
        rnd_push(1'b0, 1'b1);
        checks++;
        if (count !== CW'(7) || fetch_ready !== 1'b0) begin
            errors++; $display("FAIL wrap_at7 count=%0d ready=%b exp 7/0", count, fetch_ready);
        end
        rnd_push(1'b0, 1'b0);
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL wrap_no_push_at7 obs=%h exp=%h", obs, m_outs());
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, $urandom, $urandom, p, 1'b0, 1'b0, 1'b0);
            p += 32'd8;
            checks++;
            if (obs !== m_outs()) begin
                errors++; $display("FAIL wrap_pair%0d obs=%h exp=%h", i, obs, m_outs());
            end
        end
    endtask

    task automatic test_flush();
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        repeat (2) rnd_push(1'b1, 1'b0);
        rnd_push(1'b0, 1'b1);
        checks++;
        if (count !== CW'(5)) begin
            errors++; $display("FAIL flush_setup count=%0d exp 5", count);
        end
        cycle(1'b1, $urandom, $urandom, 32'h400, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs !== {1'b0, 1'b0, NOP, 32'h0, NOP, 32'h0, CW'(0), 1'b1}) begin
            errors++; $display("FAIL flush_override obs=%h exp=%h", obs, {1'b0, 1'b0, NOP, 32'h0, NOP, 32'h0, CW'(0), 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        repeat (2) rnd_push(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; fetch_valid = 1'b1; stall = 1'b0; flush = 1'b0; hazard_control = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        checks++;
        if (obs !== {1'b0, 1'b0, NOP, 32'h0, NOP, 32'h0, CW'(0), 1'b1}) begin
            errors++; $display("FAIL reset_mid obs=%h exp=%h", obs, {1'b0, 1'b0, NOP, 32'h0, NOP, 32'h0, CW'(0), 1'b1});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom & 32'hffff_fff8,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
            checks++;
            if (obs !== m_outs()) begin
                errors++; $display("FAIL random%0d obs=%h exp=%h", i, obs, m_outs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_hazard();
        test_full();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
